// File: rtl/wavetable_rd_pkg.sv
// Shared definitions for the wavetable read engine: default widths and FSM state encodings.
package wavetable_rd_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int ADDR_WIDTH_DEF  = 10;
    localparam int PHASE_WIDTH_DEF = 32;
    localparam int FRAC_WIDTH_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_CAP  = 3'd3,
        ST_OUT  = 3'd4
    } state_e;

endpackage

// File: rtl/wavetable_rd_lerp.sv
// Combinational linear interpolator: result = s0 + floor((s1 - s0) * frac / 2**FRAC_WIDTH).
module wt_lerp
    import wavetable_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_WIDTH = FRAC_WIDTH_DEF
) (
    input  logic signed [DATA_WIDTH-1:0] s0,
    input  logic signed [DATA_WIDTH-1:0] s1,
    input  logic        [FRAC_WIDTH-1:0] frac,
    output logic signed [DATA_WIDTH-1:0] result
);

    localparam int PW = DATA_WIDTH + FRAC_WIDTH + 2;

    logic signed [DATA_WIDTH:0] diff;
    logic signed [PW-1:0]       diff_x;
    logic signed [PW-1:0]       frac_x;
    logic signed [PW-1:0]       prod;
    logic signed [PW-1:0]       sum;

    assign diff   = {s1[DATA_WIDTH-1], s1} - {s0[DATA_WIDTH-1], s0};
    assign diff_x = {{(FRAC_WIDTH+1){diff[DATA_WIDTH]}}, diff};
    assign frac_x = {{(DATA_WIDTH+2){1'b0}}, frac};
    assign prod   = diff_x * frac_x;
    // Arithmetic shift floors toward -inf; the sum always stays between s0 and s1.
    assign sum    = (prod >>> FRAC_WIDTH) + {{(FRAC_WIDTH+2){s0[DATA_WIDTH-1]}}, s0};
    assign result = sum[DATA_WIDTH-1:0];

endmodule

// File: rtl/wavetable_rd.sv
// Wavetable read engine: phase accumulator, two-word fetch on memory port b, interpolated sample out.
module wavetable_rd
    import wavetable_rd_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int FRAC_WIDTH  = FRAC_WIDTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   en_i,
    input  logic                   req_i,
    input  logic                   sync_i,
    input  logic [PHASE_WIDTH-1:0] phase_inc_i,
    output logic                   mem_ce_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    output logic                   mem_we_o,
    input  logic [DATA_WIDTH-1:0]  mem_q_i,
    output logic [DATA_WIDTH-1:0]  sample_o,
    output logic                   sample_vld_o,
    output logic                   busy_o,
    output logic                   overrun_o,
    output state_e                 dbg_state_o
);

    state_e                  state_q, state_d;
    logic [PHASE_WIDTH-1:0]  phase_q, p_q, inc_q, p_src;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [FRAC_WIDTH-1:0]   frac;
    logic [DATA_WIDTH-1:0]   s0_q, s1_q, lerp_res;
    logic                    accept;

    // Handshake: req_i is a single-cycle strobe, taken only when en_i is high and the FSM is IDLE;
    // anything else is dropped (and flagged as overrun when it hits a busy engine).
    assign accept = req_i && en_i && (state_q == ST_IDLE);
    assign p_src  = sync_i ? '0 : phase_q;
    assign idx    = p_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
    assign frac   = p_q[PHASE_WIDTH-ADDR_WIDTH-1 -: FRAC_WIDTH];

    assign mem_we_o    = 1'b0;
    assign busy_o      = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_RD0;
            ST_RD0:  state_d = ST_RD1;
            ST_RD1:  state_d = ST_CAP;
            ST_CAP:  state_d = ST_OUT;
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    wt_lerp #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_lerp (
        .s0     (s0_q),
        .s1     (s1_q),
        .frac   (frac),
        .result (lerp_res)
    );

    // Memory port b has one cycle of read latency: word idx lands during RD1, word idx+1 during CAP.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            phase_q      <= '0;
            p_q          <= '0;
            inc_q        <= '0;
            s0_q         <= '0;
            s1_q         <= '0;
            sample_o     <= '0;
            sample_vld_o <= 1'b0;
            mem_ce_o     <= 1'b0;
            mem_addr_o   <= '0;
            overrun_o    <= 1'b0;
        end else begin
            sample_vld_o <= (state_q == ST_OUT);
            if (req_i && en_i && (state_q != ST_IDLE)) overrun_o <= 1'b1;
            if (accept) begin
                p_q        <= p_src;
                inc_q      <= phase_inc_i;
                mem_ce_o   <= 1'b1;
                mem_addr_o <= p_src[PHASE_WIDTH-1 -: ADDR_WIDTH];
            end
            case (state_q)
                ST_RD0: begin
                    mem_ce_o   <= 1'b1;
                    mem_addr_o <= idx + ADDR_WIDTH'(1);
                end
                ST_RD1: begin
                    mem_ce_o <= 1'b0;
                    s0_q     <= mem_q_i;
                end
                ST_CAP:  s1_q <= mem_q_i;
                ST_OUT: begin
                    sample_o <= lerp_res;
                    phase_q  <= p_q + inc_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wavetable_rd.sv
// Directed bench for wavetable_rd with a registered-read memory model and a queue-based scoreboard.
module tb_wavetable_rd;
    import wavetable_rd_pkg::*;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        en_i = 1'b1;
    logic        req_i = 1'b0;
    logic        sync_i = 1'b0;
    logic [31:0] phase_inc_i = '0;
    logic        mem_ce_o;
    logic [9:0]  mem_addr_o;
    logic        mem_we_o;
    logic [15:0] mem_q_i = '0;
    logic [15:0] sample_o;
    logic        sample_vld_o;
    logic        busy_o;
    logic        overrun_o;
    state_e      dbg_state_o;

    logic [15:0] mem [1024];
    logic [15:0] exp_q[$];
    int          cyc_q[$];
    logic [9:0]  addr_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    wavetable_rd dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .en_i         (en_i),
        .req_i        (req_i),
        .sync_i       (sync_i),
        .phase_inc_i  (phase_inc_i),
        .mem_ce_o     (mem_ce_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_q_i      (mem_q_i),
        .sample_o     (sample_o),
        .sample_vld_o (sample_vld_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o),
        .dbg_state_o  (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(posedge clk_i) if (mem_ce_o) mem_q_i <= mem[mem_addr_o];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_req(input logic s, input logic [31:0] inc, input logic [15:0] e_samp,
                          input logic [9:0] a0, input logic [9:0] a1);
        @(negedge clk_i);
        req_i = 1'b1; sync_i = s; phase_inc_i = inc;
        exp_q.push_back(e_samp);
        cyc_q.push_back(cyc + 5);
        addr_q.push_back(a0);
        addr_q.push_back(a1);
        @(negedge clk_i);
        req_i = 1'b0; sync_i = 1'b1; phase_inc_i = 32'hDEAD_BEEF;
        repeat (4) @(negedge clk_i);
    endtask

    initial begin : monitor
        logic [15:0] e;
        logic [9:0]  a;
        int          c;
        forever begin
            @(negedge clk_i);
            if (sample_vld_o) begin
                if (exp_q.size() == 0) check("unexpected_vld", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    check("sample", {16'd0, sample_o}, {16'd0, e});
                    check("latency", cyc, c);
                end
            end
            if (mem_ce_o) begin
                if (addr_q.size() == 0) check("unexpected_ce", 32'd1, 32'd0);
                else begin
                    a = addr_q.pop_front();
                    check("mem_addr", {22'd0, mem_addr_o}, {22'd0, a});
                end
                check("mem_we", {31'd0, mem_we_o}, 32'd0);
            end
        end
    end

    initial begin : driver
        for (int k = 0; k < 1024; k++) mem[k] = 16'(16 * k);
        repeat (3) @(negedge clk_i);
        check("rst_ce", {31'd0, mem_ce_o}, 32'd0);
        check("rst_addr", {22'd0, mem_addr_o}, 32'd0);
        check("rst_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_sample", {16'd0, sample_o}, 32'd0);
        check("rst_vld", {31'd0, sample_vld_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_overrun", {31'd0, overrun_o}, 32'd0);
        rstn_i = 1'b1;

        // Ramp table, fixed increment from phase 0.
        do_req(1'b0, 32'h0020_0000, 16'd0,  10'd0, 10'd1);
        do_req(1'b0, 32'h0020_0000, 16'd8,  10'd0, 10'd1);
        do_req(1'b0, 32'h0020_0000, 16'd16, 10'd1, 10'd2);
        do_req(1'b0, 32'h0020_0000, 16'd24, 10'd1, 10'd2);

        // Wrap-around: phase 0xFFE00000 -> idx 1023, second word from address 0.
        do_req(1'b1, 32'hFFE0_0000, 16'd0,    10'd0,    10'd1);
        do_req(1'b0, 32'h0020_0000, 16'd8184, 10'd1023, 10'd0);

        // Signed interpolation and floor rounding.
        mem[0] = 16'hFF9C; mem[1] = 16'd101;
        do_req(1'b1, 32'h0010_0000, 16'hFF9C, 10'd0, 10'd1);
        do_req(1'b0, 32'h0010_0000, 16'hFFCE, 10'd0, 10'd1);
        mem[0] = 16'd1; mem[1] = 16'd0;
        do_req(1'b1, 32'h0020_0000, 16'd1, 10'd0, 10'd1);
        do_req(1'b0, 32'h0020_0000, 16'd0, 10'd0, 10'd1);
        mem[0] = 16'd0; mem[1] = 16'd16;

        // Overrun: second request two clocks into a sequence is dropped.
        @(negedge clk_i);
        req_i = 1'b1; sync_i = 1'b1; phase_inc_i = 32'h0020_0000;
        exp_q.push_back(16'd0); cyc_q.push_back(cyc + 5);
        addr_q.push_back(10'd0); addr_q.push_back(10'd1);
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
        check("busy_mid", {31'd0, busy_o}, 32'd1);
        req_i = 1'b1; sync_i = 1'b0; phase_inc_i = 32'h0100_0000;
        @(negedge clk_i);
        req_i = 1'b0;
        check("overrun_set", {31'd0, overrun_o}, 32'd1);
        repeat (2) @(negedge clk_i);
        do_req(1'b0, 32'h0020_0000, 16'd8, 10'd0, 10'd1);
        check("overrun_sticky", {31'd0, overrun_o}, 32'd1);

        // Reset during RD1 with phase at 0x00400000.
        @(negedge clk_i);
        req_i = 1'b1; sync_i = 1'b0; phase_inc_i = 32'h0020_0000;
        addr_q.push_back(10'd1);
        @(negedge clk_i);
        req_i = 1'b0;
        @(posedge clk_i);
        #2;
        check("rd1_state", {29'd0, dbg_state_o}, {29'd0, ST_RD1});
        rstn_i = 1'b0;
        #1;
        check("mid_rst_ce", {31'd0, mem_ce_o}, 32'd0);
        check("mid_rst_vld", {31'd0, sample_vld_o}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check("mid_rst_overrun", {31'd0, overrun_o}, 32'd0);
        check("mid_rst_sample", {16'd0, sample_o}, 32'd0);
        repeat (4) @(negedge clk_i);
        rstn_i = 1'b1;
        do_req(1'b0, 32'h0020_0000, 16'd0, 10'd0, 10'd1);

        // Disabled engine ignores requests entirely.
        en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); req_i = 1'b1;
            @(negedge clk_i); req_i = 1'b0;
            check("dis_busy", {31'd0, busy_o}, 32'd0);
        end
        repeat (5) @(negedge clk_i);
        check("dis_overrun", {31'd0, overrun_o}, 32'd0);
        en_i = 1'b1;

        repeat (6) @(negedge clk_i);
        check("pending_samples", exp_q.size(), 32'd0);
        check("pending_addrs", addr_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
